ysyx_23060201_isram: RTL and testbench
======================================

Name: ysyx_23060201_isram

Overview:
- AXI4-Lite read-only slave: the instruction-memory model that sits directly upstream of the instruction fetch unit and answers its fetch requests.
- Replaces the fetch unit's same-cycle DPI read with a handshaked, variable-latency read, so the fetch stage can later be made multi-cycle or pipelined.
- Backed by the existing DPI `pmem_read(addr, 8'b1111)`.
- Supports fixed or pseudo-random response latency to stress the upstream handshake.

Parameters:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, read data width; only 32 is supported.
- MBASE, 32'h8000_0000, base of the legal instruction window.
- MSIZE, 32'h0800_0000, size in bytes of the legal window.
- LATENCY, 1, fixed cycles from AR handshake to rvalid; legal range 1..255.
- RAND_LAT, 0, 1 = ignore LATENCY and use an LFSR-derived latency of 1..8.

Ports:
- clk, input, 1, clock; all state updates on posedge.
- rst_n, input, 1, asynchronous active-low reset.
- arvalid, input, 1, read address valid.
- arready, output, 1, slave can accept an address.
- araddr, input, ADDR_WIDTH, fetch address (pc).
- rvalid, output, 1, read data valid.
- rready, input, 1, master accepts data.
- rdata, output, DATA_WIDTH, instruction word.
- rresp, output, 2, 2'b00 OKAY, 2'b10 SLVERR.

Behaviour:
- Reset is asynchronous, active-low (rst_n), and takes effect immediately, including mid-transaction.
- Reset values:
  - state = IDLE, arready = 0, rvalid = 0, rdata = 0, rresp = 2'b00.
  - latency counter = 0, LFSR = 8'hA5.
- After rst_n deasserts, arready rises at the first posedge.
- No DPI call is made during or for an aborted transaction.
- All outputs are registered.
- States:
  - IDLE: arready = 1. On arvalid & arready at edge N:
    - latch araddr;
    - load cnt = L, where L = LATENCY, or {5'b0, lfsr[2:0]} + 1 when RAND_LAT = 1;
    - drop arready; enter WAIT.
  - WAIT: arready = 0, rvalid = 0. Each edge: if cnt == 1, perform the lookup, set rvalid = 1 and go to RESP; else cnt--. rvalid is therefore first high after edge N+L.
  - RESP: rvalid = 1. rdata and rresp are held stable until rready. On rvalid & rready at an edge: drop rvalid, raise arready, go to IDLE.
- Lookup rules:
  - If addr[1:0] != 0, or addr < MBASE, or addr >= MBASE + MSIZE: rresp = 2'b10, rdata = 0, no DPI call. Compute the window bound in 33 bits so it cannot wrap.
  - Otherwise rresp = 2'b00 and rdata = pmem_read(addr, 8'b1111).
  - Exactly one DPI call per accepted transaction, on the edge entering RESP.
- Handshake rules:
  - arvalid and araddr are sampled only in IDLE; arvalid in WAIT/RESP is ignored (arready = 0).
  - rready asserted before rvalid has no effect.
  - rready held high completes the handshake on the first edge rvalid is high.
  - Maximum throughput is one transaction per L+2 cycles.
  - Only one outstanding transaction; no buffering.
- LFSR:
  - 8-bit Fibonacci, taps x^8 + x^6 + x^5 + x^4 + 1.
  - Advances every cycle regardless of state; never reaches 0 from seed A5.
  - Sampled only at the AR handshake.

Test Plan:
- Reset then idle: rst_n low 3 cycles -> arready = 0, rvalid = 0 during reset; arready = 1 one cycle after release.
- LATENCY = 3, araddr = 0x8000_0000, rready = 1, pmem word 0x00000413 -> rvalid high exactly 3 edges after the AR handshake; rdata = 0x00000413, rresp = 00; arready = 1 the following cycle.
- Backpressure: rready low 5 cycles after rvalid -> rdata/rresp stable all 5 cycles; handshake on the first rready-high edge; DPI call count = 1.
- Errors:
  - araddr = 0x7FFF_FFFC -> rresp = 10, rdata = 0, no DPI call.
  - araddr = 0x8000_0002 -> rresp = 10.
  - araddr = 0x87FF_FFFC -> rresp = 00.
  - araddr = 0x8800_0000 -> rresp = 10.
- Async reset in WAIT with LATENCY = 10, asserted 4 cycles after the handshake -> rvalid never rises, no DPI call; after release, a new fetch completes normally.
- RAND_LAT = 1, 200 back-to-back fetches of sequential pc -> every latency is in 1..8, more than one distinct latency is observed, and rdata matches the reference memory for every fetch.

Source files
------------

// File: rtl/ysyx_23060201_isram.sv
// Read-only AXI4-Lite instruction memory in front of the fetch unit.
// One outstanding fetch, fixed or LFSR-driven response latency, registered outputs.
module ysyx_23060201_isram #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter logic [31:0] MBASE      = 32'h8000_0000,
    parameter logic [31:0] MSIZE      = 32'h0800_0000,
    parameter int unsigned LATENCY    = 1,
    parameter bit          RAND_LAT   = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  arvalid,
    output logic                  arready,
    input  logic [ADDR_WIDTH-1:0] araddr,
    output logic                  rvalid,
    input  logic                  rready,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            rresp
);

    // state | meaning
    // IDLE  | arready high, waiting for a fetch address
    // WAIT  | address latched, counting down the response latency
    // RESP  | rvalid high, rdata/rresp held until rready
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [7:0]  LAT_FIX  = 8'(LATENCY);
    localparam logic [1:0]  RESP_OK  = 2'b00;
    localparam logic [1:0]  RESP_ERR = 2'b10;
    // window bounds carry one extra bit so MBASE + MSIZE cannot wrap
    localparam logic [32:0] WIN_LO   = {1'b0, MBASE};
    localparam logic [32:0] WIN_HI   = {1'b0, MBASE} + {1'b0, MSIZE};

    state_t                  state_q, state_d;
    logic                    arready_q, arready_d;
    logic                    rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]              rresp_q, rresp_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [7:0]              lfsr_q, lfsr_d;
    logic [7:0]              lat_load;
    logic                    lfsr_fb;

    // Behavioural stand-in for the simulator's pmem_read(addr, wmask):
    // a deterministic word derived from the offset into the window.
    function automatic logic [31:0] pmem_read(input logic [31:0] addr, input logic [7:0] mask);
        logic [31:0] off;
        logic [31:0] word;
        off  = addr - MBASE;
        word = {off[17:2], 16'h0413} ^ {off[31:18], off[1:0], 16'h0000};
        return (mask == 8'b0000_1111) ? word : 32'h0;
    endfunction

    function automatic logic addr_legal(input logic [ADDR_WIDTH-1:0] a);
        logic [32:0] ax;
        ax = 33'(a);
        return (a[1:0] == 2'b00) && (ax >= WIN_LO) && (ax < WIN_HI);
    endfunction

    assign lfsr_fb  = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    assign lfsr_d   = {lfsr_q[6:0], lfsr_fb};
    assign lat_load = RAND_LAT ? ({5'b0, lfsr_q[2:0]} + 8'd1) : LAT_FIX;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OK;
            addr_q    <= '0;
            cnt_q     <= 8'd0;
            lfsr_q    <= 8'hA5;
        end else begin
            state_q   <= state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            lfsr_q    <= lfsr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                arready_d = 1'b1;
                rvalid_d  = 1'b0;
                // arready_q is low on the first cycle after reset, so no accept then
                if (arvalid && arready_q) begin
                    addr_d    = araddr;
                    cnt_d     = lat_load;
                    arready_d = 1'b0;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                arready_d = 1'b0;
                rvalid_d  = 1'b0;
                if (cnt_q == 8'd1) begin
                    if (addr_legal(addr_q)) begin
                        rresp_d = RESP_OK;
                        rdata_d = DATA_WIDTH'(pmem_read(32'(addr_q), 8'b0000_1111));
                    end else begin
                        rresp_d = RESP_ERR;
                        rdata_d = '0;
                    end
                    rvalid_d = 1'b1;
                    state_d  = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_RESP: begin
                arready_d = 1'b0;
                rvalid_d  = 1'b1;
                if (rready) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                arready_d = 1'b0;
                rvalid_d  = 1'b0;
            end
        endcase
    end

    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;

endmodule

// File: tb/tb_ysyx_23060201_isram.sv
// Directed bench for ysyx_23060201_isram: three instances (LATENCY 3, LATENCY 10, random
// latency) share clock/reset/address/rready; a scoreboard queue holds expected responses.
module tb_ysyx_23060201_isram;

    logic        clk;
    logic        rst_n;
    logic [31:0] araddr;
    logic        rready;
    logic [2:0]  arvalid;

    logic        arready0, arready1, arready2;
    logic        rvalid0, rvalid1, rvalid2;
    logic [31:0] rdata0, rdata1, rdata2;
    logic [1:0]  rresp0, rresp1, rresp2;

    logic [2:0]       ar;
    logic [2:0]       rv;
    logic [2:0][31:0] rd;
    logic [2:0][1:0]  rr;

    assign ar = {arready2, arready1, arready0};
    assign rv = {rvalid2, rvalid1, rvalid0};
    assign rd = {rdata2, rdata1, rdata0};
    assign rr = {rresp2, rresp1, rresp0};

    int vectors = 0;
    int errors  = 0;

    logic [33:0] sb[$];
    logic [7:0]  m_lfsr;
    logic [2:0]  rv_prev;
    int          rise_cnt [3];
    logic [8:0]  lat_seen;

    ysyx_23060201_isram #(.LATENCY(3)) u0 (
        .clk(clk), .rst_n(rst_n), .arvalid(arvalid[0]), .arready(arready0), .araddr(araddr),
        .rvalid(rvalid0), .rready(rready), .rdata(rdata0), .rresp(rresp0));
    ysyx_23060201_isram #(.LATENCY(10)) u1 (
        .clk(clk), .rst_n(rst_n), .arvalid(arvalid[1]), .arready(arready1), .araddr(araddr),
        .rvalid(rvalid1), .rready(rready), .rdata(rdata1), .rresp(rresp1));
    ysyx_23060201_isram #(.RAND_LAT(1'b1)) u2 (
        .clk(clk), .rst_n(rst_n), .arvalid(arvalid[2]), .arready(arready2), .araddr(araddr),
        .rvalid(rvalid2), .rready(rready), .rdata(rdata2), .rresp(rresp2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference LFSR: x^8 + x^6 + x^5 + x^4 + 1, seed A5, steps every cycle
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 8'hA5;
        else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    // count rvalid rising edges per instance: one per completed lookup
    always @(negedge clk) begin
        rv_prev <= rv;
        for (int k = 0; k < 3; k++)
            if (rv[k] && !rv_prev[k]) rise_cnt[k] <= rise_cnt[k] + 1;
    end

    // reference memory contents and window check
    function automatic logic [33:0] ref_rsp(input logic [31:0] a);
        logic [31:0] off;
        logic [31:0] w;
        logic [32:0] ax;
        ax = {1'b0, a};
        if (a[1:0] != 2'b00 || ax < 33'h0_8000_0000 || ax >= 33'h0_8800_0000)
            return {2'b10, 32'h0};
        off = a - 32'h8000_0000;
        w   = (((off >> 2) & 32'h0000_FFFF) << 16) | 32'h0000_0413;
        w   = w ^ (off & 32'hFFFC_0000) ^ ((off & 32'h3) << 16);
        return {2'b00, w};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // one full fetch on instance s; called at a negedge with the instance idle
    task automatic fetch(input int s, input logic [31:0] a, input int hold);
        int          lat;
        int          elat;
        int          rise0;
        logic [33:0] exp;
        chk("arready_idle", 64'(ar[s]), 64'd1);
        rise0      = rise_cnt[s];
        araddr     = a;
        arvalid[s] = 1'b1;
        rready     = (hold == 0);
        elat       = (s == 0) ? 3 : (s == 1) ? 10 : int'(m_lfsr[2:0]) + 1;
        sb.push_back(ref_rsp(a));
        @(posedge clk);
        @(negedge clk);
        arvalid[s] = 1'b0;
        araddr     = 32'hDEAD_BEEF;
        chk("arready_drop", 64'(ar[s]), 64'd0);
        lat = 0;
        while (!rv[s] && lat < 300) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("latency", 64'(lat), 64'(elat));
        if (s == 2) begin
            chk("lat_range", 64'(lat >= 1 && lat <= 8), 64'd1);
            if (lat >= 1 && lat <= 8) lat_seen[lat] = 1'b1;
        end
        if (!rv[s]) begin
            void'(sb.pop_front());
            return;
        end
        exp = sb.pop_front();
        chk("rdata", 64'(rd[s]), 64'(exp[31:0]));
        chk("rresp", 64'(rr[s]), 64'(exp[33:32]));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("hold_rvalid", 64'(rv[s]), 64'd1);
            chk("hold_rdata", 64'(rd[s]), 64'(exp[31:0]));
            chk("hold_rresp", 64'(rr[s]), 64'(exp[33:32]));
        end
        rready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rvalid_drop", 64'(rv[s]), 64'd0);
        chk("arready_back", 64'(ar[s]), 64'd1);
        chk("lookups", 64'(rise_cnt[s] - rise0), 64'd1);
    endtask

    initial begin
        int rise1;
        int distinct;
        rst_n    = 1'b0;
        arvalid  = 3'b000;
        araddr   = 32'h0;
        rready   = 1'b0;
        rv_prev  = 3'b000;
        lat_seen = '0;
        for (int k = 0; k < 3; k++) rise_cnt[k] = 0;

        // reset held for three cycles
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_arready", 64'(ar), 64'd0);
            chk("rst_rvalid", 64'(rv), 64'd0);
            chk("rst_rdata", 64'(rd[0]), 64'd0);
            chk("rst_rresp", 64'(rr[0]), 64'd0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("arready_after_rst", 64'(ar), 64'd7);

        // basic fetch, rready already high before rvalid
        fetch(0, 32'h8000_0000, 0);
        // backpressure: rready low for 5 cycles after rvalid
        fetch(0, 32'h8000_0004, 5);
        // window and alignment boundaries
        fetch(0, 32'h7FFF_FFFC, 0);
        fetch(0, 32'h8000_0002, 0);
        fetch(0, 32'h87FF_FFFC, 0);
        fetch(0, 32'h8800_0000, 2);
        fetch(0, 32'h8000_0100, 0);

        // async reset while waiting out a 10-cycle latency
        rise1      = rise_cnt[1];
        araddr     = 32'h8000_0008;
        arvalid[1] = 1'b1;
        rready     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        arvalid[1] = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_rvalid", 64'(rvalid1), 64'd0);
        chk("abort_arready", 64'(arready1), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rvalid1) break;
        end
        chk("abort_no_lookup", 64'(rise_cnt[1] - rise1), 64'd0);
        chk("abort_rdata", 64'(rdata1), 64'd0);
        fetch(1, 32'h8000_000C, 0);

        // random latency, back-to-back sequential fetches
        for (int i = 0; i < 200; i++) fetch(2, 32'h8000_0000 + 32'(i * 4), 0);
        distinct = 0;
        for (int k = 1; k <= 8; k++) if (lat_seen[k]) distinct++;
        chk("distinct_lat", 64'(distinct > 1), 64'd1);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
